unified_mem_arbiter: RTL

- Shares one single-port unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage RV32 pipeline.
- Sequences each access as issue, then wait-for-ack, then respond.
- Arbitration gives the data port priority, with an anti-starvation override for fetch.
- Fetches can be cancelled by a branch flush, and a timeout guards against a memory that never acknowledges.

---
 rtl/unified_mem_arbiter_pkg.sv | 20 ++
 rtl/arb_sat_counter.sv | 40 ++++
 rtl/unified_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  function automatic logic is_wait(arb_state_e s);
    return (s == WAIT_IF) || (s == WAIT_DM);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at LIMIT.
// One-cycle update latency; clear has priority over increment.
module arb_sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             at_limit_o
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between fetch and load/store: issue, wait-for-ack, respond.
// Data port has priority; fetch is forced through after STARVE_MAX back-to-back data grants.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT_CYC);

  arb_state_e state_q, state_d;

  logic              mem_en_q,     mem_en_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;
  logic              if_ready_q,   if_ready_d;
  logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
  logic              dm_ready_q,   dm_ready_d;
  logic [DATA_W-1:0] dm_rdata_q,   dm_rdata_d;
  logic              err_q,        err_d;
  logic              drop_q,       drop_d;

  logic          if_eff;
  logic          gnt_any;
  logic          gnt_sel;
  logic          starve_max;
  logic          wait_lim;
  logic          drop_now;
  logic          timeout;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;

  // A fetch raised together with a flush is stale and never competes.
  always_comb begin
    if_eff   = if_req & ~if_flush;
    gnt_any  = (state_q == IDLE) & (dm_req | if_eff);
    gnt_sel  = (if_eff & (~dm_req | starve_max)) ? GNT_IF : GNT_DM;
    drop_now = drop_q | if_flush;
    timeout  = is_wait(state_q) & ~mem_ack & wait_lim;
  end

  arb_sat_counter #(
    .WIDTH (SW),
    .LIMIT (STARVE_MAX)
  ) u_starve_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (gnt_any & ((gnt_sel == GNT_IF) | ~if_req)),
    .inc_i      (gnt_any & (gnt_sel == GNT_DM) & if_req),
    .cnt_o      (starve_cnt),
    .at_limit_o (starve_max)
  );

  arb_sat_counter #(
    .WIDTH (WW),
    .LIMIT (TIMEOUT_CYC - 1)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (gnt_any),
    .inc_i      (is_wait(state_q) & ~mem_ack),
    .cnt_o      (wait_cnt),
    .at_limit_o (wait_lim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = (gnt_sel == GNT_IF) ? WAIT_IF : WAIT_DM;
        end
      end
      WAIT_IF: begin
        if (mem_ack) begin
          state_d = drop_now ? IDLE : RESP;
        end else if (wait_lim) begin
          state_d = RESP;
        end
      end
      WAIT_DM: begin
        if (mem_ack || wait_lim) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    if_ready_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_ready_d   = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    err_d        = err_q | timeout;
    drop_d       = 1'b0;

    if (gnt_any) begin
      mem_en_d = 1'b1;
      if (gnt_sel == GNT_IF) begin
        mem_we_d     = 1'b0;
        mem_addr_d   = if_addr;
        mem_wdata_d  = '0;
        mem_funct3_d = FETCH_FUNCT3;
      end else begin
        mem_we_d     = dm_we;
        mem_addr_d   = dm_addr;
        mem_wdata_d  = dm_wdata;
        mem_funct3_d = dm_funct3;
      end
    end

    case (state_q)
      WAIT_IF: begin
        drop_d = drop_now & ~mem_ack & ~wait_lim;
        if (mem_ack) begin
          if (!drop_now) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (wait_lim) begin
          if_ready_d = 1'b1;
          if_rdata_d = '0;
        end
      end
      WAIT_DM: begin
        if (mem_ack) begin
          dm_ready_d = 1'b1;
          dm_rdata_d = mem_we_q ? '0 : mem_rdata;
        end else if (wait_lim) begin
          dm_ready_d = 1'b1;
          dm_rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= '0;
      if_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_ready_q   <= 1'b0;
      dm_rdata_q   <= '0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      if_ready_q   <= if_ready_d;
      if_rdata_q   <= if_rdata_d;
      dm_ready_q   <= dm_ready_d;
      dm_rdata_q   <= dm_rdata_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_funct3 = mem_funct3_q;
  assign if_ready   = if_ready_q;
  assign if_rdata   = if_rdata_q;
  assign dm_ready   = dm_ready_q;
  assign dm_rdata   = dm_rdata_q;
  assign err        = err_q;

endmodule
